// File: rtl/fan_governor.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fan_governor : temperature-to-duty fan governor with spin-up, overtemp and stall FSM
// Rev 1.0
// -----------------------------------------------------------------------------
module fan_governor #(
  parameter int TEMP_LO       = 40,
  parameter int SLOPE         = 2,
  parameter int MIN_DUTY      = 20,
  parameter int TEMP_CRIT     = 95,
  parameter int HYST          = 5,
  parameter int STEP_CYCLES   = 100_000,
  parameter int SPINUP_CYCLES = 200_000_000,
  parameter int RPS_PERIOD    = 100_000_000,
  parameter int MIN_RPS       = 10,
  parameter int STALL_LIMIT   = 3,
  parameter int TEMP_TIMEOUT  = 500_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        gov_en,
  input  logic        temp_valid,
  input  logic [7:0]  temp_c,
  input  logic [19:0] fan_rps,
  input  logic        fault_clr,
  output logic [7:0]  duty_cycle,
  output logic        force_on,
  output logic        fan_enable,
  output logic        stall_fault,
  output logic        overtemp,
  output logic [1:0]  gov_state
);

  typedef enum logic [1:0] {
    SPINUP   = 2'd0,
    RUN      = 2'd1,
    OVERTEMP = 2'd2,
    STALL    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  temp_q, temp_d, target_q, target_d, duty_q, duty_d;
  logic        force_q, force_d, en_q, en_d, fault_q, fault_d, ot_q, ot_d;
  logic [31:0] step_q, step_d, spin_q, spin_d, tmo_q, tmo_d;
  logic [31:0] rps_tmr_q, rps_tmr_d, low_q, low_d;
  logic [31:0] lin_duty, low_inc;
  logic        step_tick, tmo_active, too_hot, cool_enough, rps_sample, rps_low;

  assign step_tick   = (step_q == 32'(STEP_CYCLES - 1));
  assign tmo_active  = (tmo_q >= 32'(TEMP_TIMEOUT));
  assign too_hot     = (32'(temp_q) >= 32'(TEMP_CRIT));
  assign cool_enough = (32'(temp_q) <= 32'(TEMP_CRIT - HYST));
  assign rps_sample  = (state_q == RUN) && (rps_tmr_q == 32'(RPS_PERIOD - 1));
  assign rps_low     = (fan_rps < 20'(MIN_RPS));
  assign low_inc     = rps_low ? (low_q + 32'd1) : 32'd0;

  // Linear ramp is evaluated in 32 bits so large slopes cannot wrap before the clamp.
  always_comb begin
    lin_duty = 32'(MIN_DUTY) + (32'(temp_q) - 32'(TEMP_LO)) * 32'(SLOPE);
    if (32'(temp_q) <= 32'(TEMP_LO)) begin
      target_d = 8'(MIN_DUTY);
    end else if (lin_duty > 32'd100) begin
      target_d = 8'd100;
    end else begin
      target_d = lin_duty[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPINUP: begin
        if (too_hot || tmo_active)                     state_d = OVERTEMP;
        else if (spin_q >= 32'(SPINUP_CYCLES - 1))     state_d = RUN;
      end
      RUN: begin
        if (too_hot || tmo_active)                               state_d = OVERTEMP;
        else if (rps_sample && (low_inc >= 32'(STALL_LIMIT)))    state_d = STALL;
      end
      OVERTEMP: begin
        if (cool_enough && !tmo_active) state_d = RUN;
      end
      STALL: begin
        if (fault_clr) state_d = SPINUP;
      end
      default: state_d = SPINUP;
    endcase
  end

  always_comb begin
    temp_d    = temp_valid ? temp_c : temp_q;
    tmo_d     = temp_valid ? 32'd0 : (tmo_active ? tmo_q : tmo_q + 32'd1);
    step_d    = step_tick ? 32'd0 : step_q + 32'd1;
    // Phase counters restart from zero on every entry into their state.
    spin_d    = (state_q == SPINUP && state_d == SPINUP) ? spin_q + 32'd1 : 32'd0;
    rps_tmr_d = (state_q == RUN && state_d == RUN) ? (rps_sample ? 32'd0 : rps_tmr_q + 32'd1) : 32'd0;
    low_d     = (state_d != RUN) ? 32'd0 : (rps_sample ? low_inc : low_q);

    duty_d = duty_q;
    if (state_d != RUN) begin
      duty_d = 8'd100;
    end else if (state_q == RUN && step_tick) begin
      if (duty_q < target_q)      duty_d = duty_q + 8'd1;
      else if (duty_q > target_q) duty_d = duty_q - 8'd1;
    end

    force_d = (state_d != RUN);
    ot_d    = (state_d == OVERTEMP);
    fault_d = (state_d == STALL);
    en_d    = gov_en;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= SPINUP;
      temp_q    <= 8'd0;
      target_q  <= 8'(MIN_DUTY);
      duty_q    <= 8'd100;
      force_q   <= 1'b1;
      en_q      <= 1'b0;
      fault_q   <= 1'b0;
      ot_q      <= 1'b0;
      step_q    <= 32'd0;
      spin_q    <= 32'd0;
      tmo_q     <= 32'd0;
      rps_tmr_q <= 32'd0;
      low_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      temp_q    <= temp_d;
      target_q  <= target_d;
      duty_q    <= duty_d;
      force_q   <= force_d;
      en_q      <= en_d;
      fault_q   <= fault_d;
      ot_q      <= ot_d;
      step_q    <= step_d;
      spin_q    <= spin_d;
      tmo_q     <= tmo_d;
      rps_tmr_q <= rps_tmr_d;
      low_q     <= low_d;
    end
  end

  assign duty_cycle  = duty_q;
  assign force_on    = force_q;
  assign fan_enable  = en_q;
  assign stall_fault = fault_q;
  assign overtemp    = ot_q;
  assign gov_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fan_governor.sv
`default_nettype none
// tb_fan_governor : table vectors, directed corner sequences and randomized
// stimulus checked every cycle against an edge-indexed behavioural model.
`timescale 1ns/1ps
module tb_fan_governor;
  localparam int STEP_C = 4, SPIN_C = 20, RPS_P = 50, TMO = 1000;
  localparam int TEMP_LO = 40, SLOPE = 2, MIN_DUTY = 20, TEMP_CRIT = 95, HYST = 5;
  localparam int MIN_RPS = 10, STALL_LIMIT = 3;
  localparam int S_SPIN = 0, S_RUN = 1, S_OT = 2, S_STALL = 3;

  logic        sys_clk = 1'b0, sys_rst = 1'b0, gov_en = 1'b0, temp_valid = 1'b0, fault_clr = 1'b0;
  logic [7:0]  temp_c = 8'd0;
  logic [19:0] fan_rps = 20'd0;
  logic [7:0]  duty_cycle;
  logic        force_on, fan_enable, stall_fault, overtemp;
  logic [1:0]  gov_state;

  fan_governor #(
    .TEMP_LO(TEMP_LO), .SLOPE(SLOPE), .MIN_DUTY(MIN_DUTY), .TEMP_CRIT(TEMP_CRIT), .HYST(HYST),
    .STEP_CYCLES(STEP_C), .SPINUP_CYCLES(SPIN_C), .RPS_PERIOD(RPS_P), .MIN_RPS(MIN_RPS),
    .STALL_LIMIT(STALL_LIMIT), .TEMP_TIMEOUT(TMO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .gov_en(gov_en), .temp_valid(temp_valid),
    .temp_c(temp_c), .fan_rps(fan_rps), .fault_clr(fault_clr), .duty_cycle(duty_cycle),
    .force_on(force_on), .fan_enable(fan_enable), .stall_fault(stall_fault),
    .overtemp(overtemp), .gov_state(gov_state)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests, n_fail;

  // Model: everything is expressed as a function of the edge index since reset
  // and the edge at which each phase began.
  int m_e, m_last_v, m_spin_start, m_run_start, m_state, m_low, m_temp, m_tgt, m_duty;
  bit m_fault, m_en, m_sampled;

  function automatic int target_of(input int t);
    int v;
    if (t <= TEMP_LO) return MIN_DUTY;
    v = MIN_DUTY + (t - TEMP_LO) * SLOPE;
    return (v > 100) ? 100 : v;
  endfunction

  task automatic model_reset();
    m_e = 0; m_last_v = -1; m_spin_start = 0; m_run_start = 0; m_state = S_SPIN;
    m_low = 0; m_temp = 0; m_tgt = MIN_DUTY; m_duty = 100;
    m_fault = 0; m_en = 0; m_sampled = 0;
  endtask

  task automatic model_edge(input bit tv, input int tc, input int rps, input bit fc, input bit en);
    int ns, low;
    bit hot, tmo_act, tick, smp;
    hot     = (m_temp >= TEMP_CRIT);
    tmo_act = ((m_e - m_last_v - 1) >= TMO);
    tick    = ((m_e % STEP_C) == STEP_C - 1);
    ns = m_state; low = m_low; smp = 0;
    case (m_state)
      S_SPIN: begin
        if (hot || tmo_act) ns = S_OT;
        else if (m_e - m_spin_start >= SPIN_C - 1) ns = S_RUN;
      end
      S_RUN: begin
        smp = (((m_e - m_run_start) % RPS_P) == RPS_P - 1);
        if (smp) low = (rps < MIN_RPS) ? low + 1 : 0;
        if (hot || tmo_act) ns = S_OT;
        else if (smp && low >= STALL_LIMIT) ns = S_STALL;
      end
      S_OT: if (m_temp <= TEMP_CRIT - HYST && !tmo_act) ns = S_RUN;
      default: if (fc) ns = S_SPIN;
    endcase
    if (ns == S_RUN && m_state != S_RUN) m_run_start = m_e + 1;
    if (ns == S_SPIN && m_state != S_SPIN) m_spin_start = m_e + 1;
    m_low = (ns == S_RUN) ? low : 0;
    if (ns != S_RUN) m_duty = 100;
    else if (m_state == S_RUN && tick) begin
      if (m_duty < m_tgt) m_duty++;
      else if (m_duty > m_tgt) m_duty--;
    end
    m_tgt = target_of(m_temp);
    if (tv) begin m_temp = tc; m_last_v = m_e; end
    m_fault = (ns == S_STALL); m_en = en; m_sampled = smp; m_state = ns;
    m_e++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, clock once, compare all outputs to the model.
  task automatic step(input bit tv, input int tc, input bit fc);
    logic [13:0] act_v, exp_v;
    temp_valid = tv; temp_c = 8'(tc); fault_clr = fc;
    @(posedge sys_clk);
    if (!sys_rst) model_edge(tv, tc, int'(fan_rps), fc, gov_en);
    @(negedge sys_clk);
    temp_valid = 1'b0; fault_clr = 1'b0;
    act_v = {duty_cycle, force_on, fan_enable, stall_fault, overtemp, gov_state};
    exp_v = {8'(m_duty), m_state != S_RUN, m_en, m_fault, m_state == S_OT, 2'(m_state)};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_outputs edge %0d: got duty=%0d frc=%b en=%b flt=%b ot=%b st=%0d expected duty=%0d frc=%b en=%b flt=%b ot=%b st=%0d",
               m_e, act_v[13:6], act_v[5], act_v[4], act_v[3], act_v[2], act_v[1:0],
               exp_v[13:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
    end
  endtask

  task automatic wait_state(input string name, input int st, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (int'(gov_state) == st) break;
      step(1'b0, 0, 1'b0);
    end
    chk(name, int'(gov_state), st);
  endtask

  task automatic wait_sample(input string name);
    for (int i = 0; i < RPS_P + 5; i++) begin
      step(i == 0, 50, 1'b0);
      if (m_sampled) return;
    end
    n_tests++; n_fail++;
    $display("FAIL %s: no fan_rps sample within %0d cycles", name, RPS_P + 5);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(gov_state), S_SPIN);
    chk({tag, "_duty"}, int'(duty_cycle), 100);
    chk({tag, "_force_on"}, int'(force_on), 1);
    chk({tag, "_fan_enable"}, int'(fan_enable), 0);
    chk({tag, "_stall_fault"}, int'(stall_fault), 0);
    chk({tag, "_overtemp"}, int'(overtemp), 0);
  endtask

  typedef struct {
    int temp;
    int wait_cyc;
    int exp_state;
    int exp_duty;
  } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0]  = '{60, 200, S_RUN, 60};
    tbl[1]  = '{41, 200, S_RUN, 22};
    tbl[2]  = '{80, 350, S_RUN, 100};
    tbl[3]  = '{96, 5, S_OT, 100};
    tbl[4]  = '{91, 5, S_OT, 100};
    tbl[5]  = '{90, 2, S_RUN, 100};
    tbl[6]  = '{50, 300, S_RUN, 40};
    tbl[7]  = '{40, 120, S_RUN, 20};
    tbl[8]  = '{255, 3, S_OT, 100};
    tbl[9]  = '{0, 2, S_RUN, 100};
    tbl[10] = '{45, 400, S_RUN, 30};

    n_tests = 0; n_fail = 0;
    model_reset();
    fan_rps = 20'd1000;

    #2 sys_rst = 1'b1;
    #1 chk_reset_vals("por");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0; gov_en = 1'b1;

    // Spin-up length, then slew 100 -> 20.
    step(1'b1, 30, 1'b0);
    repeat (18) step(1'b0, 0, 1'b0);
    chk("spinup_last_state", int'(gov_state), S_SPIN);
    chk("spinup_last_duty", int'(duty_cycle), 100);
    chk("spinup_force_on", int'(force_on), 1);
    step(1'b0, 0, 1'b0);
    chk("run_entry_state", int'(gov_state), S_RUN);
    chk("run_entry_force_on", int'(force_on), 0);
    chk("run_entry_duty", int'(duty_cycle), 100);
    repeat (400) step(1'b0, 0, 1'b0);
    chk("settle_min_duty", int'(duty_cycle), 20);

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].temp, 1'b0);
      for (int k = 1; k < tbl[i].wait_cyc; k++) step(1'b0, 0, 1'b0);
      chk($sformatf("tbl%0d_state", i), int'(gov_state), tbl[i].exp_state);
      chk($sformatf("tbl%0d_duty", i), int'(duty_cycle), tbl[i].exp_duty);
    end

    // Overtemp entry latency: temp_q updates on the strobe edge, state one edge later.
    step(1'b1, 96, 1'b0);
    chk("ot_pre_state", int'(gov_state), S_RUN);
    step(1'b0, 0, 1'b0);
    chk("ot_state", int'(gov_state), S_OT);
    chk("ot_flag", int'(overtemp), 1);
    chk("ot_force_on", int'(force_on), 1);
    step(1'b1, 50, 1'b0);
    wait_state("ot_exit", S_RUN, 10);

    // Stall, stays stalled when hot, clears to spin-up.
    fan_rps = 20'd5;
    wait_state("stall_entry", S_STALL, 200);
    chk("stall_fault_set", int'(stall_fault), 1);
    step(1'b1, 96, 1'b0);
    repeat (10) step(1'b0, 0, 1'b0);
    chk("stall_hot_state", int'(gov_state), S_STALL);
    chk("stall_hot_ot", int'(overtemp), 0);
    fan_rps = 20'd1000;
    step(1'b0, 0, 1'b1);
    chk("fault_clr_state", int'(gov_state), S_SPIN);
    chk("fault_clr_flag", int'(stall_fault), 0);
    step(1'b1, 50, 1'b0);
    wait_state("recover_run", S_RUN, 20);

    // low, low, ok, low -> no stall; two more lows -> stall.
    wait_sample("sync");
    fan_rps = 20'd5;
    wait_sample("low1");
    wait_sample("low2");
    fan_rps = 20'd1000;
    wait_sample("ok");
    fan_rps = 20'd5;
    wait_sample("low1b");
    chk("llol_no_stall", int'(gov_state), S_RUN);
    chk("llol_no_fault", int'(stall_fault), 0);
    wait_sample("low2b");
    wait_sample("low3b");
    chk("llol_then_stall", int'(gov_state), S_STALL);

    // Asynchronous reset while stalled.
    #2 sys_rst = 1'b1;
    #1 chk_reset_vals("mid_rst");
    model_reset();
    fan_rps = 20'd1000;
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Temperature timeout.
    step(1'b1, 50, 1'b0);
    wait_state("tmo_run", S_RUN, 40);
    wait_state("tmo_overtemp", S_OT, 1100);
    chk("tmo_ot_flag", int'(overtemp), 1);
    step(1'b1, 50, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("tmo_recover", int'(gov_state), S_RUN);

    // Randomized traffic, alternating dense and sparse temperature strobes.
    for (int i = 0; i < 15000; i++) begin
      bit tv;
      gov_en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 49) == 0)
        fan_rps = ($urandom_range(0, 2) == 0) ? 20'($urandom_range(0, 9)) : 20'($urandom_range(10, 3000));
      if (((i / 3000) % 2) == 1) tv = ($urandom_range(0, 799) == 0);
      else                       tv = ($urandom_range(0, 9) == 0);
      step(tv, int'($urandom_range(20, 110)), ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
